// File: rtl/pe_ctrl_pkg.sv
// Shared types, sizes and the result packing helper for the quad Hex_PE cluster sequencer.
package pe_ctrl_pkg;

    localparam int NUM_PE = 4;
    localparam int BYTE_W = 8;
    localparam int VEC_W  = 128;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        OUTPUT
    } state_e;

    // Lane 0 occupies the least significant byte of the result word.
    function automatic logic [NUM_PE*BYTE_W-1:0] pack_lanes(
        input logic [BYTE_W-1:0] l0,
        input logic [BYTE_W-1:0] l1,
        input logic [BYTE_W-1:0] l2,
        input logic [BYTE_W-1:0] l3
    );
        return {l3, l2, l1, l0};
    endfunction

endpackage

// File: rtl/pe_lane_capture.sv
// One lane's OFM capture: the first valid after a clear wins, later pulses are ignored.
module pe_lane_capture
    import pe_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear_i,
    input  logic              valid_i,
    input  logic [BYTE_W-1:0] ofm_i,
    output logic              got_o,
    output logic [BYTE_W-1:0] ofm_o
);

    logic              got_q;
    logic [BYTE_W-1:0] ofm_q;

    always_ff @(posedge clk) begin
        if (reset_n || clear_i) begin
            got_q <= 1'b0;
            ofm_q <= '0;
        end else if (valid_i && !got_q) begin
            got_q <= 1'b1;
            ofm_q <= ofm_i;
        end
    end

    assign got_o = got_q;
    assign ofm_o = ofm_q;

endmodule

// File: rtl/pe_cluster_quad_ctrl.sv
// Sequencer for the quad Hex_PE cluster: clears the PEs, streams IFM/weight beats,
// collects the four lane bytes and returns them as one 32-bit result per job.
module pe_cluster_quad_ctrl
    import pe_ctrl_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cfg_start,
    input  logic [CNT_W-1:0]        cfg_num_beats,
    input  logic [CNT_W-1:0]        cfg_num_jobs,
    output logic                    busy,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [VEC_W-1:0]        in_ifm,
    input  logic [NUM_PE*VEC_W-1:0] in_weight,
    output logic [VEC_W-1:0]        IFM,
    output logic [VEC_W-1:0]        Weight_0,
    output logic [VEC_W-1:0]        Weight_1,
    output logic [VEC_W-1:0]        Weight_2,
    output logic [VEC_W-1:0]        Weight_3,
    output logic [NUM_PE-1:0]       PE_reset,
    output logic [NUM_PE-1:0]       PE_finish,
    input  logic [BYTE_W-1:0]       OFM_0,
    input  logic [BYTE_W-1:0]       OFM_1,
    input  logic [BYTE_W-1:0]       OFM_2,
    input  logic [BYTE_W-1:0]       OFM_3,
    input  logic [15:0]             valid,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [31:0]             res_data,
    output logic                    err_timeout
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    state_e                  state_q;
    logic [CNT_W-1:0]        nbeats_q;
    logic [CNT_W-1:0]        njobs_q;
    logic [CNT_W-1:0]        beats_q;
    logic [CNT_W-1:0]        jobs_q;
    logic [CNT_W-1:0]        beats_d;
    logic [CNT_W-1:0]        jobs_d;
    logic [TMO_W-1:0]        tmo_q;
    logic                    in_ready_q;
    logic                    res_valid_q;
    logic                    err_q;
    logic [NUM_PE-1:0]       pe_reset_q;
    logic [NUM_PE-1:0]       finish_q;
    logic [VEC_W-1:0]        ifm_q;
    logic [NUM_PE*VEC_W-1:0] weight_q;

    logic                    accept;
    logic                    lane_clear;
    logic                    all_got;
    logic [NUM_PE-1:0]       lane_cap;
    logic [NUM_PE-1:0]       lane_got;
    logic [BYTE_W-1:0]       lane_ofm_in [NUM_PE];
    logic [BYTE_W-1:0]       lane_ofm    [NUM_PE];
    logic                    unused_valid_hi;

    assign accept     = in_valid && in_ready_q;
    assign lane_clear = (state_q == CLEAR);
    assign lane_cap   = valid[NUM_PE-1:0] & {NUM_PE{state_q == DRAIN}};
    assign all_got    = &(lane_got | lane_cap);
    assign beats_d    = beats_q + CNT_W'(1);
    assign jobs_d     = jobs_q + CNT_W'(1);

    assign unused_valid_hi = ^valid[15:NUM_PE];

    assign lane_ofm_in[0] = OFM_0;
    assign lane_ofm_in[1] = OFM_1;
    assign lane_ofm_in[2] = OFM_2;
    assign lane_ofm_in[3] = OFM_3;

    for (genvar i = 0; i < NUM_PE; i++) begin : g_lane
        pe_lane_capture u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .clear_i (lane_clear),
            .valid_i (lane_cap[i]),
            .ofm_i   (lane_ofm_in[i]),
            .got_o   (lane_got[i]),
            .ofm_o   (lane_ofm[i])
        );
    end

    // Outputs are registered on the transition into each state; the vector path
    // defaults to a zero bubble so idle cycles add nothing to the MACs.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            state_q     <= IDLE;
            nbeats_q    <= '0;
            njobs_q     <= '0;
            beats_q     <= '0;
            jobs_q      <= '0;
            tmo_q       <= '0;
            in_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
            pe_reset_q  <= '1;
            finish_q    <= '0;
            ifm_q       <= '0;
            weight_q    <= '0;
        end else begin
            ifm_q    <= '0;
            weight_q <= '0;
            finish_q <= '0;
            case (state_q)
                IDLE: begin
                    pe_reset_q <= '1;
                    if (cfg_start && (cfg_num_beats != '0) && (cfg_num_jobs != '0)) begin
                        nbeats_q <= cfg_num_beats;
                        njobs_q  <= cfg_num_jobs;
                        jobs_q   <= '0;
                        err_q    <= 1'b0;
                        state_q  <= CLEAR;
                    end
                end
                CLEAR: begin
                    beats_q    <= '0;
                    tmo_q      <= '0;
                    pe_reset_q <= '0;
                    in_ready_q <= 1'b1;
                    state_q    <= STREAM;
                end
                STREAM: begin
                    if (accept) begin
                        ifm_q    <= in_ifm;
                        weight_q <= in_weight;
                        beats_q  <= beats_d;
                        if (beats_d == nbeats_q) begin
                            finish_q   <= '1;
                            in_ready_q <= 1'b0;
                            state_q    <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (all_got) begin
                        res_valid_q <= 1'b1;
                        state_q     <= OUTPUT;
                    end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                        err_q       <= 1'b1;
                        res_valid_q <= 1'b1;
                        state_q     <= OUTPUT;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                OUTPUT: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        jobs_q      <= jobs_d;
                        pe_reset_q  <= '1;
                        state_q     <= (jobs_d == njobs_q) ? IDLE : CLEAR;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = (state_q != IDLE);
    assign in_ready    = in_ready_q;
    assign res_valid   = res_valid_q;
    assign err_timeout = err_q;
    assign PE_reset    = pe_reset_q;
    assign PE_finish   = finish_q;
    assign IFM         = ifm_q;
    assign Weight_0    = weight_q[0*VEC_W +: VEC_W];
    assign Weight_1    = weight_q[1*VEC_W +: VEC_W];
    assign Weight_2    = weight_q[2*VEC_W +: VEC_W];
    assign Weight_3    = weight_q[3*VEC_W +: VEC_W];
    assign res_data    = pack_lanes(lane_ofm[0], lane_ofm[1], lane_ofm[2], lane_ofm[3]);

endmodule

// File: tb/tb_pe_cluster_quad_ctrl.sv
// Directed bench for pe_cluster_quad_ctrl; cycle 0 is the cycle in which cfg_start is driven,
// and outputs are sampled 1 time unit after each rising edge.
module tb_pe_cluster_quad_ctrl;

    localparam logic [127:0] ONES = {16{8'h01}};
    localparam logic [127:0] W0   = {16{8'h02}};
    localparam logic [127:0] W1   = {16{8'h03}};
    localparam logic [127:0] W2   = {16{8'h04}};
    localparam logic [127:0] W3   = {16{8'h05}};

    logic         clk;
    logic         reset_n;
    logic         cfg_start;
    logic [15:0]  cfg_num_beats;
    logic [15:0]  cfg_num_jobs;
    logic         busy;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_ifm;
    logic [511:0] in_weight;
    logic [127:0] IFM;
    logic [127:0] Weight_0;
    logic [127:0] Weight_1;
    logic [127:0] Weight_2;
    logic [127:0] Weight_3;
    logic [3:0]   PE_reset;
    logic [3:0]   PE_finish;
    logic [7:0]   OFM_0;
    logic [7:0]   OFM_1;
    logic [7:0]   OFM_2;
    logic [7:0]   OFM_3;
    logic [15:0]  valid;
    logic         res_valid;
    logic         res_ready;
    logic [31:0]  res_data;
    logic         err_timeout;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int hs     = 0;

    pe_cluster_quad_ctrl dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cfg_start     (cfg_start),
        .cfg_num_beats (cfg_num_beats),
        .cfg_num_jobs  (cfg_num_jobs),
        .busy          (busy),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_ifm        (in_ifm),
        .in_weight     (in_weight),
        .IFM           (IFM),
        .Weight_0      (Weight_0),
        .Weight_1      (Weight_1),
        .Weight_2      (Weight_2),
        .Weight_3      (Weight_3),
        .PE_reset      (PE_reset),
        .PE_finish     (PE_finish),
        .OFM_0         (OFM_0),
        .OFM_1         (OFM_1),
        .OFM_2         (OFM_2),
        .OFM_3         (OFM_3),
        .valid         (valid),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .err_timeout   (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (res_valid && res_ready) hs++;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic tick_to(input int target);
        while (cyc < target) tick();
    endtask

    // Pulses cfg_start in cycle 0 and then scrambles cfg_* to show they are latched.
    task automatic start_run(input int nb, input int nj);
        cfg_num_beats = 16'(nb);
        cfg_num_jobs  = 16'(nj);
        cfg_start     = 1'b1;
        cyc           = 0;
        tick();
        cfg_start     = 1'b0;
        cfg_num_beats = 16'd7;
        cfg_num_jobs  = 16'd9;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        tick(); tick(); tick();
        reset_n = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%0h exp=0", busy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready got=%0h exp=0", in_ready); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_res_valid got=%0h exp=0", res_valid); end
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got=%0h exp=0", err_timeout); end
        checks++; if (PE_finish !== 4'h0) begin errors++; $display("[TB] FAIL reset_pe_finish got=%h exp=0", PE_finish); end
        checks++; if (PE_reset !== 4'hF) begin errors++; $display("[TB] FAIL reset_pe_reset got=%h exp=f", PE_reset); end
        checks++; if (res_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_res_data got=%h exp=0", res_data); end
        checks++; if (IFM !== 128'h0 || Weight_0 !== 128'h0 || Weight_3 !== 128'h0) begin
            errors++; $display("[TB] FAIL reset_vectors got IFM=%h W0=%h W3=%h exp=0", IFM, Weight_0, Weight_3);
        end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_idle_busy got=%0h exp=0", busy); end
    endtask

    task automatic test_basic();
        logic [127:0] e_ifm;
        logic [127:0] e_w0;
        logic [127:0] e_w3;
        logic [3:0]   e_fin;
        in_ifm    = ONES;
        in_weight = {W3, W2, W1, W0};
        in_valid  = 1'b1;
        res_ready = 1'b1;
        start_run(4, 1);
        checks++; if (PE_reset !== 4'hF || busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL basic_clear_c1 got PE_reset=%h busy=%0h in_ready=%0h exp f/1/0", PE_reset, busy, in_ready);
        end
        tick();
        checks++; if (in_ready !== 1'b1 || PE_reset !== 4'h0) begin
            errors++; $display("[TB] FAIL basic_stream_c2 got in_ready=%0h PE_reset=%h exp 1/0", in_ready, PE_reset);
        end
        for (int c = 3; c <= 7; c++) begin
            tick();
            e_ifm = (c <= 6) ? ONES : 128'h0;
            e_w0  = (c <= 6) ? W0 : 128'h0;
            e_w3  = (c <= 6) ? W3 : 128'h0;
            e_fin = (c == 6) ? 4'hF : 4'h0;
            checks++; if (IFM !== e_ifm || Weight_0 !== e_w0 || Weight_3 !== e_w3) begin
                errors++; $display("[TB] FAIL basic_vec_c%0d got IFM=%h W0=%h W3=%h exp IFM=%h", c, IFM, Weight_0, Weight_3, e_ifm);
            end
            checks++; if (PE_finish !== e_fin) begin
                errors++; $display("[TB] FAIL basic_finish_c%0d got=%h exp=%h", c, PE_finish, e_fin);
            end
        end
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL basic_ready_drop got=%0h exp=0", in_ready); end
        tick_to(9);
        OFM_0 = 8'h11; OFM_1 = 8'h22; OFM_2 = 8'h33; OFM_3 = 8'h44;
        valid = 16'h000F;
        tick();
        valid = 16'h0;
        checks++; if (res_valid !== 1'b1 || res_data !== 32'h44332211) begin
            errors++; $display("[TB] FAIL basic_result got valid=%0h data=%h exp 1/44332211", res_valid, res_data);
        end
        tick();
        checks++; if (busy !== 1'b0 || res_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL basic_done got busy=%0h res_valid=%0h exp 0/0", busy, res_valid);
        end
    endtask

    task automatic test_bubbles();
        logic [127:0] e_ifm;
        logic [127:0] e_w1;
        logic [3:0]   e_fin;
        in_valid = 1'b0;
        start_run(4, 1);
        tick();
        for (int c = 2; c <= 10; c++) begin
            if (c >= 3) begin
                e_ifm = ((c % 2 == 1) && (c <= 9)) ? ONES : 128'h0;
                e_w1  = ((c % 2 == 1) && (c <= 9)) ? W1 : 128'h0;
                e_fin = (c == 9) ? 4'hF : 4'h0;
                checks++; if (IFM !== e_ifm || Weight_1 !== e_w1 || PE_finish !== e_fin) begin
                    errors++; $display("[TB] FAIL bubble_c%0d got IFM=%h W1=%h fin=%h exp IFM=%h fin=%h", c, IFM, Weight_1, PE_finish, e_ifm, e_fin);
                end
            end
            in_valid = (c % 2 == 0) && (c <= 8);
            tick();
        end
        tick_to(12);
        OFM_0 = 8'h11; OFM_1 = 8'h22; OFM_2 = 8'h33; OFM_3 = 8'h44;
        valid = 16'h000F;
        tick();
        valid = 16'h0;
        checks++; if (res_valid !== 1'b1 || res_data !== 32'h44332211) begin
            errors++; $display("[TB] FAIL bubble_result got valid=%0h data=%h exp 1/44332211", res_valid, res_data);
        end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL bubble_done got busy=%0h exp 0", busy); end
    endtask

    task automatic test_staggered();
        in_valid = 1'b1;
        start_run(4, 1);
        tick_to(3);
        OFM_0 = 8'hEE; OFM_1 = 8'hEE; OFM_2 = 8'hEE; OFM_3 = 8'hEE;
        valid = 16'h000F;
        tick();
        valid = 16'h0;
        tick_to(6);
        in_valid = 1'b0;
        checks++; if (PE_finish !== 4'hF) begin errors++; $display("[TB] FAIL stagger_finish got=%h exp=f", PE_finish); end
        tick();
        OFM_0 = 8'h11; OFM_1 = 8'h22; OFM_2 = 8'h33; OFM_3 = 8'h44;
        valid = 16'hF001;
        tick();
        valid = 16'h0004;
        tick();
        OFM_0 = 8'hFF;
        valid = 16'h0001;
        tick();
        valid = 16'h0;
        tick();
        checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL stagger_early got res_valid=%0h exp 0", res_valid); end
        valid = 16'h000A;
        tick();
        valid = 16'h0;
        checks++; if (res_valid !== 1'b1 || res_data !== 32'h44332211) begin
            errors++; $display("[TB] FAIL stagger_result got valid=%0h data=%h exp 1/44332211", res_valid, res_data);
        end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL stagger_done got busy=%0h exp 0", busy); end
    endtask

    task automatic test_timeout();
        in_valid = 1'b1;
        start_run(2, 1);
        tick_to(4);
        in_valid = 1'b0;
        tick();
        OFM_0 = 8'h11; OFM_1 = 8'h22; OFM_2 = 8'h33; OFM_3 = 8'h44;
        valid = 16'h0007;
        tick();
        valid = 16'h0;
        tick_to(67);
        checks++; if (res_valid !== 1'b0 || err_timeout !== 1'b0) begin
            errors++; $display("[TB] FAIL timeout_early got res_valid=%0h err=%0h exp 0/0", res_valid, err_timeout);
        end
        tick();
        checks++; if (res_valid !== 1'b1 || err_timeout !== 1'b1) begin
            errors++; $display("[TB] FAIL timeout_fire got res_valid=%0h err=%0h exp 1/1", res_valid, err_timeout);
        end
        checks++; if (res_data !== 32'h00332211) begin
            errors++; $display("[TB] FAIL timeout_data got=%h exp=00332211", res_data);
        end
        tick();
        checks++; if (busy !== 1'b0 || err_timeout !== 1'b1) begin
            errors++; $display("[TB] FAIL timeout_idle got busy=%0h err=%0h exp 0/1", busy, err_timeout);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e_data;
        logic [7:0]  b0;
        int          hs_base;
        hs_base   = hs;
        in_valid  = 1'b1;
        res_ready = 1'b1;
        start_run(2, 3);
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("[TB] FAIL b2b_err_cleared got=%0h exp=0", err_timeout); end
        for (int j = 0; j < 3; j++) begin
            res_ready = (j != 1);
            for (int i = 0; i < 50 && PE_finish !== 4'hF; i++) tick();
            checks++; if (PE_finish !== 4'hF) begin errors++; $display("[TB] FAIL b2b_finish_job%0d got=%h exp=f", j, PE_finish); end
            b0 = 8'(16 * (j + 1));
            tick(); tick(); tick();
            OFM_0 = b0; OFM_1 = b0 + 8'd1; OFM_2 = b0 + 8'd2; OFM_3 = b0 + 8'd3;
            e_data = {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0};
            valid = 16'h000F;
            tick();
            valid = 16'h0;
            checks++; if (res_valid !== 1'b1 || res_data !== e_data) begin
                errors++; $display("[TB] FAIL b2b_result_job%0d got valid=%0h data=%h exp 1/%h", j, res_valid, res_data, e_data);
            end
            if (j == 1) begin
                for (int i = 0; i < 10; i++) begin
                    tick();
                    checks++; if (res_valid !== 1'b1 || res_data !== e_data) begin
                        errors++; $display("[TB] FAIL b2b_stall_%0d got valid=%0h data=%h exp 1/%h", i, res_valid, res_data, e_data);
                    end
                end
                res_ready = 1'b1;
            end
            tick();
            if (j < 2) begin
                checks++; if (PE_reset !== 4'hF || in_ready !== 1'b0 || busy !== 1'b1) begin
                    errors++; $display("[TB] FAIL b2b_clear_job%0d got PE_reset=%h in_ready=%0h busy=%0h exp f/0/1", j, PE_reset, in_ready, busy);
                end
            end else begin
                checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_done got busy=%0h exp 0", busy); end
            end
        end
        in_valid = 1'b0;
        tick(); tick();
        checks++; if (hs - hs_base !== 3) begin
            errors++; $display("[TB] FAIL b2b_handshakes got=%0d exp=3", hs - hs_base);
        end
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1;
        start_run(8, 1);
        tick_to(4);
        checks++; if (IFM !== ONES) begin errors++; $display("[TB] FAIL midrst_running got IFM=%h exp=%h", IFM, ONES); end
        reset_n = 1'b1;
        tick();
        reset_n = 1'b0;
        checks++; if (busy !== 1'b0 || in_ready !== 1'b0 || res_valid !== 1'b0 || PE_finish !== 4'h0) begin
            errors++; $display("[TB] FAIL midrst_ctrl got busy=%0h in_ready=%0h res_valid=%0h fin=%h exp 0", busy, in_ready, res_valid, PE_finish);
        end
        checks++; if (PE_reset !== 4'hF) begin errors++; $display("[TB] FAIL midrst_pe_reset got=%h exp=f", PE_reset); end
        checks++; if (IFM !== 128'h0 || Weight_2 !== 128'h0) begin
            errors++; $display("[TB] FAIL midrst_vectors got IFM=%h W2=%h exp=0", IFM, Weight_2);
        end
        tick(); tick();
        in_valid = 1'b0;
        checks++; if (busy !== 1'b0 || res_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL midrst_stays_idle got busy=%0h res_valid=%0h exp 0/0", busy, res_valid);
        end
    endtask

    task automatic test_zero_config();
        start_run(0, 1);
        checks++; if (busy !== 1'b0 || PE_reset !== 4'hF) begin
            errors++; $display("[TB] FAIL zero_beats got busy=%0h PE_reset=%h exp 0/f", busy, PE_reset);
        end
        tick();
        checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL zero_beats_later got busy=%0h in_ready=%0h exp 0/0", busy, in_ready);
        end
        start_run(3, 0);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL zero_jobs got busy=%0h exp 0", busy); end
    endtask

    initial begin
        reset_n       = 1'b1;
        cfg_start     = 1'b0;
        cfg_num_beats = 16'h0;
        cfg_num_jobs  = 16'h0;
        in_valid      = 1'b0;
        in_ifm        = 128'h0;
        in_weight     = 512'h0;
        OFM_0         = 8'h0;
        OFM_1         = 8'h0;
        OFM_2         = 8'h0;
        OFM_3         = 8'h0;
        valid         = 16'h0;
        res_ready     = 1'b1;

        test_reset();
        test_basic();
        test_bubbles();
        test_staggered();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_zero_config();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pe_cluster_quad_ctrl.md
Name: pe_cluster_quad_ctrl

Overview:
- Sequencer that drives the quad Hex_PE cluster, the other end of the cluster's IFM/Weight/PE_reset/PE_finish/OFM/valid interface.
- Accepts a stream of 16-byte IFM and 4×16-byte weight beats, clears the PEs, and feeds them a configured number of beats.
- Marks the final beat with PE_finish, collects the four OFM bytes as each lane's valid arrives, and returns them as one 32-bit result word over a valid/ready handshake.
- Repeats for a configured number of jobs.

Parameters:
- NUM_PE, 4, PE lanes in the cluster. Fixed at 4; the ports below are sized for 4.
- VEC_W, 128, bits per IFM/Weight vector (16 bytes).
- CNT_W, 16, width of the beat and job counters.
- TIMEOUT, 64, maximum DRAIN cycles before the controller abandons waiting for the lanes.

Ports:
- clk  in  1  clock. All logic is on the rising edge.
- reset_n  in  1  synchronous, active-high reset. The name is the team's standard one; it is asserted HIGH.
- cfg_start  in  1  one-cycle pulse that launches a run. Sampled only in IDLE.
- cfg_num_beats  in  CNT_W  beats per job. Latched on start.
- cfg_num_jobs  in  CNT_W  result words per run. Latched on start.
- busy  out  1  high in every state except IDLE.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat ready.
- in_ifm  in  VEC_W  IFM bytes of the beat; byte0 is in [7:0].
- in_weight  in  4*VEC_W  weights; lane i is in [i*VEC_W +: VEC_W].
- IFM  out  VEC_W  to the cluster.
- Weight_0..Weight_3  out  VEC_W each  to the cluster.
- PE_reset  out  4  per-lane PE clear.
- PE_finish  out  4  per-lane last-beat mark.
- OFM_0..OFM_3  in  8 each  lane results from the cluster.
- valid  in  16  cluster valid. Only [3:0] is used; [15:4] is ignored.
- res_valid  out  1  result valid.
- res_ready  in  1  result ready.
- res_data  out  32  packed result {OFM_3, OFM_2, OFM_1, OFM_0}.
- err_timeout  out  1  sticky; set on a DRAIN timeout.

Behaviour:
- Reset values:
  - busy=0, in_ready=0, res_valid=0, err_timeout=0, PE_finish=0.
  - res_data=0, IFM=0, Weight_0..3=0.
  - PE_reset=4'hF.
  - State is IDLE and all counters and capture registers are 0.
  - Reset asserted mid-operation aborts immediately to the same values. No partial result is emitted.
- IDLE:
  - PE_reset=4'hF is held.
  - cfg_start with cfg_num_beats≠0 and cfg_num_jobs≠0 latches both values and moves to CLEAR.
  - cfg_start with a zero field is ignored.
  - err_timeout is cleared on an accepted start.
- CLEAR (exactly 1 cycle):
  - PE_reset=4'hF.
  - The beat counter and the capture flags got[3:0] are cleared.
  - Next state is STREAM.
- STREAM:
  - PE_reset=0 and in_ready=1.
  - A beat is accepted when in_valid & in_ready.
  - Accepted data is registered onto IFM/Weight_i with 1-cycle latency.
  - In a cycle with no accepted beat, IFM/Weight_i are driven to 0 for the following cycle (a zero bubble, which adds nothing to the MAC).
  - PE_finish=4'hF is asserted for exactly the one cycle in which the last beat (count = cfg_num_beats) is on IFM/Weight_i.
  - After the last beat is accepted, in_ready drops in that same cycle's next state, and the state moves to DRAIN.
- DRAIN:
  - in_ready=0, and IFM/Weight_i return to 0 one cycle after the last beat.
  - For each lane i, when valid[i]=1 and got[i]=0, OFM_i is captured and got[i] is set.
  - A second valid[i] pulse is ignored. valid pulses seen outside DRAIN are ignored.
  - When got=4'hF, the state moves to OUTPUT. Lanes that arrive in the same cycle are all captured.
  - The timeout counter increments each DRAIN cycle. When it reaches TIMEOUT, err_timeout is set and the state moves to OUTPUT; missing lanes read as 0x00.
- OUTPUT:
  - res_valid=1 with res_data stable until res_ready.
  - On the handshake the job counter increments.
  - If jobs remain, the next state is CLEAR; otherwise it is IDLE.
  - res_ready held at 1 means 1-cycle acceptance; stalling res_ready holds the state with no data loss.
- Nominal timing: cfg_start at cycle 0, PE_reset at cycle 1, in_ready from cycle 2. With continuous in_valid and N beats, PE_finish is at cycle N+2.
- cfg_* changes while busy=1 have no effect.

Decomposition:
- pe_ctrl_pkg holds:
  - the state enum (IDLE, CLEAR, STREAM, DRAIN, OUTPUT);
  - the constants NUM_PE=4, BYTE_W=8, VEC_W=128;
  - a lane-pack function for res_data.
- Sub-module pe_lane_capture, instantiated 4×: holds one lane's got flag and OFM register, with clear, capture-on-valid and first-valid-wins behaviour.

Test Plan:
- Basic job: cfg_num_beats=4, cfg_num_jobs=1; in_ifm all 0x01 and weights all 0x02 with in_valid held high; the BFM pulses valid[3:0] 3 cycles after PE_finish with OFM=0x11/0x22/0x33/0x44.
  - Required: PE_reset high at cycle 1, PE_finish at cycle 6, res_data=0x44332211, busy drops after the handshake.
- Bubbles: same job with in_valid low on alternate cycles.
  - Required: zero vectors on IFM/Weight_i in the gap cycles, PE_finish still aligned with beat 4, same res_data.
- Staggered and duplicate valid: valid[0] at +1, valid[2] at +2, valid[1] and valid[3] together at +5, plus a second valid[0] pulse with OFM_0 changed to 0xFF.
  - Required: res_data=0x44332211; the duplicate is ignored.
- Timeout: lane 3 never asserts valid.
  - Required: err_timeout=1 after TIMEOUT=64 DRAIN cycles, res_data=0x00332211, state then returns to IDLE.
- Back-pressure and multiple jobs: cfg_num_jobs=3 with res_ready low for 10 cycles on job 2.
  - Required: res_data held stable during the stall, a CLEAR pulse before each job, exactly 3 result handshakes.
- Reset and zero config: reset_n asserted mid-STREAM → next cycle shows all outputs at their reset values and PE_reset=4'hF. cfg_start with cfg_num_beats=0 → stays IDLE with busy=0.
